// File: rtl/uart_tx_controller.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a pollable STATUS register.
// Define UART_PARITY_EN to add an even-parity bit (8E1 framing, STATUS[4]=1).
module uart_tx_controller #(
  parameter logic [31:0] BASE_ADDR  = 32'h0002_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  input  logic        rw,
  input  logic [1:0]  size,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH_C  = FIFO_DEPTH[AW:0];

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic PARITY_EN = 1'b1;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic PARITY_EN = 1'b0;
`endif

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          overflow;
`ifdef UART_PARITY_EN
  logic          par_q;
`endif

  logic        sel_txdata, sel_status, wr_txdata, wr_status;
  logic        fifo_empty, fifo_full, bit_end, pop, push;
  logic [7:0]  head;
  logic [31:0] status;
  logic        unused_bits;

  assign sel_txdata = (addr == BASE_ADDR);
  assign sel_status = (addr == BASE_ADDR + 32'd4);
  assign wr_txdata  = rw && sel_txdata;
  assign wr_status  = rw && sel_status;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign bit_end    = (baud_cnt == DIV_LAST);
  assign head       = fifo_mem[rd_ptr];
  // Pop happens either from idle or at the last cycle of STOP, giving back-to-back frames.
  assign pop        = !fifo_empty && (state == S_IDLE || (state == S_STOP && bit_end));
  assign push       = wr_txdata && (!fifo_full || pop);

  assign status = {16'h0, 8'(count), 3'b0, PARITY_EN, overflow,
                   state != S_IDLE, fifo_empty, fifo_full};
  assign data   = (sel_status && !rw) ? status : 'z;

  assign unused_bits = ^{size, data[31:8]};

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_txdata && !push)        overflow <= 1'b1;
      else if (wr_status && data[3]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      irq      <= 1'b1;
`ifdef UART_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      irq <= fifo_empty && (state == S_IDLE);
      if (state != S_IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: if (pop) begin
          shift_q  <= head;
`ifdef UART_PARITY_EN
          par_q    <= ^head;
`endif
          tx       <= 1'b0;
          baud_cnt <= '0;
          state    <= S_START;
        end
        S_START: if (bit_end) begin
          tx      <= shift_q[0];
          bit_idx <= '0;
          state   <= S_DATA;
        end
        S_DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            tx    <= par_q;
            state <= S_PARITY;
`else
            tx    <= 1'b1;
            state <= S_STOP;
`endif
          end else begin
            tx      <= shift_q[1];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: if (bit_end) begin
          tx    <= 1'b1;
          state <= S_STOP;
        end
`endif
        S_STOP: if (bit_end) begin
          if (pop) begin
            shift_q <= head;
`ifdef UART_PARITY_EN
            par_q   <= ^head;
`endif
            tx      <= 1'b0;
            state   <= S_START;
          end else begin
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
